// File: rtl/counter_bank_sched_pkg.sv
// Shared definitions for the counter bank: direction encoding and the
// channel-index width helper used by the top, the arbiter and the interface.
package counter_bank_sched_pkg;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Width of a channel index; never narrower than one bit so a
    // two-entry bank still has a usable select.
    function automatic int calcCw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_bank_sched_if.sv
// Request/load/done bundle between event sources and the counter bank.
// The bank sits on the slave side; requesters and loaders use the master side.
interface counter_bank_sched_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    import counter_bank_sched_pkg::*;

    localparam int CW = calcCw(CHANNELS);

    logic [CHANNELS-1:0]       req_valid;
    logic [CHANNELS-1:0]       req_dir;
    logic [CHANNELS-1:0]       req_ready;
    logic                      load_en;
    logic [CW-1:0]             load_chan;
    logic [WIDTH-1:0]          load_value;
    logic [CHANNELS*WIDTH-1:0] count_flat;
    logic                      done_valid;
    logic [CW-1:0]             done_chan;
    logic [WIDTH-1:0]          done_value;
    logic                      done_wrap;

    modport master (
        output req_valid, req_dir, load_en, load_chan, load_value,
        input  req_ready, count_flat, done_valid, done_chan, done_value, done_wrap
    );

    modport slave (
        input  req_valid, req_dir, load_en, load_chan, load_value,
        output req_ready, count_flat, done_valid, done_chan, done_value, done_wrap
    );

endinterface

// File: rtl/counter_bank_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// The pointer resets to N-1 so that requester 0 has first priority.
module rr_arbiter
    import counter_bank_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          i_req,
    input  logic                  i_advance,
    output logic [N-1:0]          o_grant,
    output logic [calcCw(N)-1:0]  o_grantIdx
);

    localparam int PW = calcCw(N);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_sel;
    logic          w_found;
    int            w_idx;

    // Scan requesters starting just after the pointer and pick the first one set.
    always_comb begin
        o_grant    = '0;
        o_grantIdx = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        w_sel      = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            w_sel = PW'(w_idx);
            if (!w_found && i_req[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                o_grantIdx     = w_sel;
                w_found        = 1'b1;
            end
        end
    end

    // Remember the last winner, but only when a grant was actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= PW'(N - 1);
        end else if (i_advance) begin
            r_ptr <= o_grantIdx;
        end
    end

endmodule

// File: rtl/counter_bank_sched.sv
// Multi-channel counter bank. One +1/-1 operation per cycle is granted
// round-robin, executed one cycle later on the shared inc/dec datapath and
// written back, with a done pulse the following cycle. A direct load port
// overrides both arbitration and a colliding write-back.
module counter_bank_sched
    import counter_bank_sched_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_bank_sched_if.slave  bus
);

    localparam int CW = calcCw(CHANNELS);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [CHANNELS-1:0]       w_arbReq;
    logic [CHANNELS-1:0]       w_grant;
    logic [CW-1:0]             w_grantIdx;
    logic                      w_accept;

    logic                      r_exValid;
    logic [CW-1:0]             r_exChan;
    logic                      r_exDir;

    logic [WIDTH-1:0]          r_count [CHANNELS];
    logic [CHANNELS*WIDTH-1:0] w_countFlat;

    logic [WIDTH-1:0]          w_operand;
    logic [WIDTH-1:0]          w_incResult;
    logic [WIDTH-1:0]          w_decResult;
    logic [WIDTH-1:0]          w_result;
    logic                      w_wrap;

    logic                      r_doneValid;
    logic [CW-1:0]             r_doneChan;
    logic [WIDTH-1:0]          r_doneValue;
    logic                      r_doneWrap;

    // A load or an active reset suppresses every grant for the cycle.
    assign w_arbReq = (bus.load_en || rst) ? '0 : bus.req_valid;
    assign w_accept = |w_grant;

    rr_arbiter #(.N(CHANNELS)) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req      (w_arbReq),
        .i_advance  (w_accept),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx)
    );

    assign bus.req_ready = w_grant;

    // Shared increment and decrement units, both with the step fixed at one.
    assign w_operand   = r_count[r_exChan];
    assign w_incResult = w_operand + WIDTH'(1);
    assign w_decResult = w_operand - WIDTH'(1);

    // Select the unit for this op and clamp instead of wrapping when saturating.
    always_comb begin
        w_result = w_decResult;
        w_wrap   = (w_operand == '0);
        if (r_exDir == DIR_INC) begin
            w_result = w_incResult;
            w_wrap   = (w_operand == ALL_ONES);
        end
        if ((SATURATE != 0) && w_wrap) begin
            w_result = w_operand;
        end
    end

    // Capture the granted op into the single execute stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exValid <= 1'b0;
            r_exChan  <= '0;
            r_exDir   <= DIR_DEC;
        end else begin
            r_exValid <= w_accept;
            if (w_accept) begin
                r_exChan <= w_grantIdx;
                r_exDir  <= bus.req_dir[w_grantIdx];
            end
        end
    end

    // Counter storage: a load beats a write-back to the same channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (bus.load_en && (bus.load_chan == CW'(i))) begin
                    r_count[i] <= bus.load_value;
                end else if (r_exValid && (r_exChan == CW'(i))) begin
                    r_count[i] <= w_result;
                end
            end
        end
    end

    // Report each executed op, including one whose result a load discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_doneValid <= 1'b0;
            r_doneChan  <= '0;
            r_doneValue <= '0;
            r_doneWrap  <= 1'b0;
        end else begin
            r_doneValid <= r_exValid;
            if (r_exValid) begin
                r_doneChan  <= r_exChan;
                r_doneValue <= w_result;
                r_doneWrap  <= w_wrap;
            end
        end
    end

    // Flatten the counter array for the outside view.
    always_comb begin
        w_countFlat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_countFlat[i*WIDTH +: WIDTH] = r_count[i];
        end
    end

    assign bus.count_flat = w_countFlat;
    assign bus.done_valid = r_doneValid;
    assign bus.done_chan  = r_doneChan;
    assign bus.done_value = r_doneValue;
    assign bus.done_wrap  = r_doneWrap;

endmodule

// File: tb/tb_counter_bank_sched.sv
// Directed bench for the counter bank. A wrapping and a saturating instance
// share the same stimulus; most expectations target the wrapping one.
module tb_counter_bank_sched;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;

    typedef struct {
        logic [3:0]  reqValid;
        logic [3:0]  reqDir;
        logic        loadEn;
        logic [1:0]  loadChan;
        logic [15:0] loadValue;
        logic [3:0]  expReady;
        logic        expDoneValid;
        logic [1:0]  expDoneChan;
        logic [15:0] expDoneValue;
        logic        expDoneWrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   passCount = 0;
    int   checkCount = 0;
    vec_t vecs[$];
    int   t1Start, t1End, t2Start, t2End, t3Start, t3End, t4Start, t4End;

    counter_bank_sched_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();
    counter_bank_sched_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) busSat ();

    assign busSat.req_valid  = bus.req_valid;
    assign busSat.req_dir    = bus.req_dir;
    assign busSat.load_en    = bus.load_en;
    assign busSat.load_chan  = bus.load_chan;
    assign busSat.load_value = bus.load_value;

    counter_bank_sched #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SATURATE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    counter_bank_sched #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SATURATE(1)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (busSat)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] rd,
                                input logic le, input logic [1:0] lc, input logic [15:0] lv,
                                input logic [3:0] er, input logic edv, input logic [1:0] edc,
                                input logic [15:0] edval, input logic edw);
        vec_t v;
        v.reqValid     = rv;
        v.reqDir       = rd;
        v.loadEn       = le;
        v.loadChan     = lc;
        v.loadValue    = lv;
        v.expReady     = er;
        v.expDoneValid = edv;
        v.expDoneChan  = edc;
        v.expDoneValue = edval;
        v.expDoneWrap  = edw;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.req_valid  = v.reqValid;
        bus.req_dir    = v.reqDir;
        bus.load_en    = v.loadEn;
        bus.load_chan  = v.loadChan;
        bus.load_value = v.loadValue;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkValue({tag, " req_ready"}, 64'(bus.req_ready), 64'(v.expReady));
        checkValue({tag, " done_valid"}, 64'(bus.done_valid), 64'(v.expDoneValid));
        if (v.expDoneValid) begin
            checkValue({tag, " done_chan"}, 64'(bus.done_chan), 64'(v.expDoneChan));
            checkValue({tag, " done_value"}, 64'(bus.done_value), 64'(v.expDoneValue));
            checkValue({tag, " done_wrap"}, 64'(bus.done_wrap), 64'(v.expDoneWrap));
        end
    endtask

    task automatic runVectors(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("%s[%0d]", tag, i - first));
        end
    endtask

    task automatic checkCounter(input logic [63:0] flat, input int ch, input logic [15:0] expected, input string tag);
        logic [15:0] actual;
        actual = flat[ch*WIDTH +: WIDTH];
        checkValue($sformatf("%s ch%0d", tag, ch), 64'(actual), 64'(expected));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst            = 1'b1;
        bus.req_valid  = '0;
        bus.req_dir    = '0;
        bus.load_en    = 1'b0;
        bus.load_chan  = '0;
        bus.load_value = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Test 1: single increment on ch2 from reset
        t1Start = vecs.size();
        vecs.push_back(mk(4'b0100, 4'b0100, 0, 2'd0, 16'h0000, 4'b0100, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd2, 16'h0001, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        t1End = vecs.size() - 1;

        // Test 2: all channels increment for 8 cycles, strict rotation
        t2Start = vecs.size();
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0001, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0010, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0100, 1, 2'd0, 16'h0001, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b1000, 1, 2'd1, 16'h0001, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0001, 1, 2'd2, 16'h0001, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0010, 1, 2'd3, 16'h0001, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0100, 1, 2'd0, 16'h0002, 0));
        vecs.push_back(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b1000, 1, 2'd1, 16'h0002, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd2, 16'h0002, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd3, 16'h0002, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        t2End = vecs.size() - 1;

        // Test 3: wrap on ch1 after loading all-ones
        t3Start = vecs.size();
        vecs.push_back(mk(4'b0000, 4'b0000, 1, 2'd1, 16'hFFFF, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 0, 2'd0, 16'h0000, 4'b0010, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0010, 4'b0000, 0, 2'd0, 16'h0000, 4'b0010, 1, 2'd1, 16'h0000, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd1, 16'hFFFF, 1));
        t3End = vecs.size() - 1;

        // Test 4: load blocks grant; load/write-back collision; back-to-back dec on ch3
        t4Start = vecs.size();
        vecs.push_back(mk(4'b0001, 4'b0001, 1, 2'd0, 16'h56AC, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 0, 2'd0, 16'h0000, 4'b0001, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd0, 16'h56AD, 0));
        vecs.push_back(mk(4'b0001, 4'b0000, 0, 2'd0, 16'h0000, 4'b0001, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1, 2'd0, 16'h1234, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd0, 16'h56AC, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 1, 2'd3, 16'hA1AF, 4'b0000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 4'b0000, 0, 2'd0, 16'h0000, 4'b1000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 4'b0000, 0, 2'd0, 16'h0000, 4'b1000, 0, 2'd0, 16'h0000, 0));
        vecs.push_back(mk(4'b1000, 4'b0000, 0, 2'd0, 16'h0000, 4'b1000, 1, 2'd3, 16'hA1AE, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd3, 16'hA1AD, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 1, 2'd3, 16'hA1AC, 0));
        vecs.push_back(mk(4'b0000, 4'b0000, 0, 2'd0, 16'h0000, 4'b0000, 0, 2'd0, 16'h0000, 0));
        t4End = vecs.size() - 1;

        // Reset state, with requests present while reset is held
        rst            = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_dir    = 4'b1111;
        bus.load_en    = 1'b0;
        bus.load_chan  = '0;
        bus.load_value = '0;
        repeat (2) @(negedge clk);
        #1;
        checkValue("reset req_ready", 64'(bus.req_ready), 64'h0);
        checkValue("reset done_valid", 64'(bus.done_valid), 64'h0);
        checkValue("reset done_chan", 64'(bus.done_chan), 64'h0);
        checkValue("reset done_value", 64'(bus.done_value), 64'h0);
        checkValue("reset done_wrap", 64'(bus.done_wrap), 64'h0);
        checkValue("reset count_flat", 64'(bus.count_flat), 64'h0);
        doReset();

        runVectors(t1Start, t1End, "single");
        checkCounter(64'(bus.count_flat), 2, 16'h0001, "single count");

        doReset();
        runVectors(t2Start, t2End, "rotate");
        checkValue("rotate count_flat", 64'(bus.count_flat), 64'h0002_0002_0002_0002);

        runVectors(t3Start, t3Start + 3, "wrap");
        checkCounter(64'(bus.count_flat), 1, 16'h0000, "wrap count");
        checkCounter(64'(busSat.count_flat), 1, 16'hFFFF, "sat count");
        checkValue("sat inc done_valid", 64'(busSat.done_valid), 64'h1);
        checkValue("sat inc done_value", 64'(busSat.done_value), 64'hFFFF);
        checkValue("sat inc done_wrap", 64'(busSat.done_wrap), 64'h1);
        runVectors(t3Start + 4, t3End, "wrapdec");
        checkValue("sat dec done_value", 64'(busSat.done_value), 64'hFFFE);
        checkValue("sat dec done_wrap", 64'(busSat.done_wrap), 64'h0);

        runVectors(t4Start, t4End, "load");
        checkCounter(64'(bus.count_flat), 0, 16'h1234, "collide count");
        checkCounter(64'(bus.count_flat), 3, 16'hA1AC, "b2b count");

        // Test 6: reset lands while an accepted op waits in the execute stage
        applyStimulus(mk(4'b0100, 4'b0100, 0, 2'd0, 16'h0000, 4'b0100, 0, 2'd0, 16'h0000, 0));
        checkValue("midop req_ready", 64'(bus.req_ready), 64'h4);
        @(negedge clk);
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_dir   = '0;
        #1;
        checkValue("midop count_flat", 64'(bus.count_flat), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkValue($sformatf("midop done_valid[%0d]", i), 64'(bus.done_valid), 64'h0);
        end
        checkCounter(64'(bus.count_flat), 2, 16'h0000, "midop count");
        applyStimulus(mk(4'b1111, 4'b1111, 0, 2'd0, 16'h0000, 4'b0001, 0, 2'd0, 16'h0000, 0));
        checkValue("midop first grant", 64'(bus.req_ready), 64'h1);
        @(negedge clk);
        bus.req_valid = '0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
